// File: rtl/adder_nios_mem_pkg.sv
// Shared constants and types for the adder_nios on-chip RAM fill/check engine.
package adder_nios_mem_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 8192;
   localparam int LEN_W  = 14;

   localparam logic MODE_FILL  = 1'b0;
   localparam logic MODE_CHECK = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CHECK,
      S_DRAIN,
      S_DONE
   } state_t;

endpackage

// File: rtl/adder_nios_pattern_gen.sv
// Word counter, wrapping RAM address and pattern value for one transfer.
module adder_nios_pattern_gen
   import adder_nios_mem_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] pattern,
   input  logic              incr,
   output logic              last,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] lim;
   logic             step;

   // The address is exactly ADDR_W bits wide, so it wraps 8191 -> 0 by itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         lim  <= '0;
         addr <= '0;
         data <= '0;
         step <= 1'b0;
      end else if (load) begin
         cnt  <= '0;
         lim  <= length - LEN_W'(1);
         addr <= base_addr;
         data <= pattern;
         step <= incr;
      end else if (advance) begin
         cnt  <= cnt + LEN_W'(1);
         addr <= addr + ADDR_W'(1);
         data <= data + {{(DATA_W-1){1'b0}}, step};
      end
   end

   assign last = (cnt == lim);

endmodule

// File: rtl/adder_nios_mem_fill_engine.sv
// Avalon-MM master that fills or verifies a word range of the on-chip RAM.
module adder_nios_mem_fill_engine
   import adder_nios_mem_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] pattern,
   input  logic              incr,
   output logic              busy,
   output logic              done,
   output logic              err_flag,
   output logic [LEN_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
);

   state_t            state;
   logic              load;
   logic              adv;
   logic              last;
   logic [ADDR_W-1:0] pg_addr;
   logic [DATA_W-1:0] pg_data;
   logic [LEN_W-1:0]  len_c;
   logic [DATA_W-1:0] exp1;
   logic [DATA_W-1:0] cmp_exp;
   logic [ADDR_W-1:0] cmp_addr;
   logic              cmp_vld;
   logic              mism;

   assign len_c = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
   assign load  = (state == S_IDLE) && start;
   assign adv   = (state == S_FILL) || (state == S_CHECK);
   assign mism  = cmp_vld && (mem_readdata != cmp_exp);

   assign mem_byteenable = 4'hF;

   adder_nios_pattern_gen u_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .advance   (adv),
      .base_addr (base_addr),
      .length    (len_c),
      .pattern   (pattern),
      .incr      (incr),
      .last      (last),
      .addr      (pg_addr),
      .data      (pg_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:
               if (start) begin
                  if (len_c == '0)
                     state <= S_DONE;
                  else if (mode == MODE_CHECK)
                     state <= S_CHECK;
                  else
                     state <= S_FILL;
               end
            S_FILL:  if (last) state <= S_DONE;
            S_CHECK: if (last) state <= S_DRAIN;
            S_DRAIN: state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Bus outputs lag the state by one register stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_writedata  <= '0;
         exp1           <= '0;
      end else begin
         busy           <= adv || (state == S_DRAIN);
         done           <= (state == S_DONE);
         mem_chipselect <= adv;
         mem_write      <= (state == S_FILL);
         if (adv) begin
            mem_address <= pg_addr;
            exp1        <= pg_data;
         end
         if (state == S_FILL)
            mem_writedata <= pg_data;
      end
   end

   // Expected word is aligned with the cycle the RAM returns its read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmp_vld        <= 1'b0;
         cmp_exp        <= '0;
         cmp_addr       <= '0;
         err_flag       <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         cmp_vld  <= mem_chipselect && !mem_write;
         cmp_exp  <= exp1;
         cmp_addr <= mem_address;
         if (load) begin
            err_flag       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
         end else if (mism) begin
            err_count <= err_count + LEN_W'(1);
            if (!err_flag) begin
               err_flag       <= 1'b1;
               first_err_addr <= cmp_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_nios_mem_fill_engine.sv
// Scoreboarded bench for the RAM fill/check engine with a 1-cycle-latency RAM model.
module tb_adder_nios_mem_fill_engine;

   typedef struct {
      logic [12:0] a;
      logic [31:0] d;
      int          rel;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [12:0] base_addr = '0;
   logic [13:0] length = '0;
   logic [31:0] pattern = '0;
   logic        incr = 1'b0;
   logic        busy;
   logic        done;
   logic        err_flag;
   logic [13:0] err_count;
   logic [12:0] first_err_addr;
   logic [12:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = '0;

   logic [31:0] ram [8192];
   logic        poke_en = 1'b0;
   logic [12:0] poke_addr = '0;
   logic [31:0] poke_data = '0;

   wr_t sb[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  c0 = 0;
   int  wr_cnt = 0;
   int  cs_cnt = 0;
   bit  busy_seen = 0;

   adder_nios_mem_fill_engine dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .mode           (mode),
      .base_addr      (base_addr),
      .length         (length),
      .pattern        (pattern),
      .incr           (incr),
      .busy           (busy),
      .done           (done),
      .err_flag       (err_flag),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_readdata   (mem_readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (poke_en)
         ram[poke_addr] <= poke_data;
      else if (mem_chipselect) begin
         if (mem_write) ram[mem_address] <= mem_writedata;
         else mem_readdata <= ram[mem_address];
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (busy) busy_seen = 1;
      if (mem_chipselect) cs_cnt++;
      if (mem_chipselect && mem_write) begin
         wr_cnt++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h", mem_address, mem_writedata);
         end else begin
            e = sb.pop_front();
            if (mem_address !== e.a || mem_writedata !== e.d || (cyc - c0) !== e.rel) begin
               failures++;
               $display("FAIL write got a=%h d=%h cyc=%0d want a=%h d=%h cyc=%0d",
                        mem_address, mem_writedata, cyc - c0, e.a, e.d, e.rel);
            end
         end
      end
   end

   task automatic push_fill(input logic [12:0] b, input int n,
                            input logic [31:0] p, input logic inc);
      wr_t e;
      for (int k = 0; k < n; k++) begin
         e.a = b + 13'(k);
         e.d = p + (inc ? 32'(k) : 32'd0);
         e.rel = k + 1;
         sb.push_back(e);
      end
   endtask

   task automatic issue(input logic m, input logic [12:0] b, input logic [13:0] n,
                        input logic [31:0] p, input logic inc);
      mode = m;
      base_addr = b;
      length = n;
      pattern = p;
      incr = inc;
      start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int rel);
      rel = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (done) begin
            rel = cyc - c0;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL done_timeout after %0d cycles", lim);
   endtask

   task automatic poke(input logic [12:0] a, input logic [31:0] d);
      @(negedge clk);
      poke_en = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, mem_chipselect, mem_write, err_flag} !== 5'b0 ||
          err_count !== 14'd0 || mem_byteenable !== 4'hF || mem_address !== 13'd0) begin
         failures++;
         $display("FAIL reset_outputs got b=%b d=%b cs=%b we=%b ef=%b ec=%0d be=%h a=%h want 0 be=f",
                  busy, done, mem_chipselect, mem_write, err_flag, err_count,
                  mem_byteenable, mem_address);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_fill();
      int rel;
      push_fill(13'h10, 4, 32'hA5A5_0000, 1'b1);
      @(negedge clk);
      issue(1'b0, 13'h10, 14'd4, 32'hA5A5_0000, 1'b1);
      wait_done(50, rel);
      checks++;
      if (rel !== 5 || busy !== 1'b0) begin
         failures++;
         $display("FAIL fill_done got cyc=%0d busy=%b want cyc=5 busy=0", rel, busy);
      end
      checks++;
      if (sb.size() !== 0 || err_count !== 14'd0) begin
         failures++;
         $display("FAIL fill_drain got left=%0d ec=%0d want 0 0", sb.size(), err_count);
      end
   endtask

   task automatic test_check_ok();
      int rel;
      @(negedge clk);
      issue(1'b1, 13'h10, 14'd4, 32'hA5A5_0000, 1'b1);
      wait_done(50, rel);
      checks++;
      if (rel !== 6 || err_count !== 14'd0 || err_flag !== 1'b0) begin
         failures++;
         $display("FAIL check_ok got cyc=%0d ec=%0d ef=%b want 6 0 0", rel, err_count, err_flag);
      end
   endtask

   task automatic test_check_err();
      int rel;
      poke(13'h12, 32'd0);
      poke(13'h13, 32'd1);
      @(negedge clk);
      issue(1'b1, 13'h10, 14'd4, 32'hA5A5_0000, 1'b1);
      wait_done(50, rel);
      checks++;
      if (rel !== 6 || err_count !== 14'd2 || err_flag !== 1'b1 || first_err_addr !== 13'h12) begin
         failures++;
         $display("FAIL check_err got cyc=%0d ec=%0d ef=%b fa=%h want 6 2 1 0012",
                  rel, err_count, err_flag, first_err_addr);
      end
   endtask

   task automatic test_wrap();
      int rel;
      push_fill(13'h1FFE, 4, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      issue(1'b0, 13'h1FFE, 14'd4, 32'hDEAD_BEEF, 1'b0);
      wait_done(50, rel);
      checks++;
      if (rel !== 5 || sb.size() !== 0 || err_flag !== 1'b0 || err_count !== 14'd0) begin
         failures++;
         $display("FAIL wrap got cyc=%0d left=%0d ef=%b ec=%0d want 5 0 0 0",
                  rel, sb.size(), err_flag, err_count);
      end
   endtask

   task automatic test_len0();
      int rel;
      @(negedge clk);
      cs_cnt = 0;
      busy_seen = 0;
      issue(1'b0, 13'h40, 14'd0, 32'h1, 1'b1);
      wait_done(20, rel);
      repeat (3) @(negedge clk);
      checks++;
      if (rel !== 1 || cs_cnt !== 0 || busy_seen !== 1'b0) begin
         failures++;
         $display("FAIL len0 got cyc=%0d cs=%0d busy=%b want 1 0 0", rel, cs_cnt, busy_seen);
      end
   endtask

   task automatic test_clamp();
      int rel;
      push_fill(13'h0, 8192, 32'h0, 1'b1);
      @(negedge clk);
      wr_cnt = 0;
      issue(1'b0, 13'h0, 14'd9000, 32'h0, 1'b1);
      wait_done(9000, rel);
      repeat (3) @(negedge clk);
      checks++;
      if (wr_cnt !== 8192 || rel !== 8193 || sb.size() !== 0) begin
         failures++;
         $display("FAIL clamp got writes=%0d cyc=%0d left=%0d want 8192 8193 0",
                  wr_cnt, rel, sb.size());
      end
   endtask

   task automatic test_start_busy();
      int rel;
      int cs_before;
      push_fill(13'h100, 6, 32'h1234, 1'b0);
      @(negedge clk);
      wr_cnt = 0;
      issue(1'b0, 13'h100, 14'd6, 32'h1234, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      mode = 1'b1;
      length = 14'd2;
      @(negedge clk);
      start = 1'b0;
      wait_done(50, rel);
      cs_before = cs_cnt;
      repeat (10) @(negedge clk);
      checks++;
      if (rel !== 7 || wr_cnt !== 6 || cs_cnt !== cs_before || sb.size() !== 0) begin
         failures++;
         $display("FAIL start_busy got cyc=%0d writes=%0d extra_cs=%0d left=%0d want 7 6 0 0",
                  rel, wr_cnt, cs_cnt - cs_before, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      int rel;
      push_fill(13'h300, 3, 32'h77, 1'b1);
      @(negedge clk);
      issue(1'b0, 13'h300, 14'd3, 32'h77, 1'b1);
      wait_done(50, rel);
      checks++;
      if (rel !== 4) begin
         failures++;
         $display("FAIL b2b_fill got cyc=%0d want 4", rel);
      end
      issue(1'b1, 13'h300, 14'd3, 32'h77, 1'b1);
      wait_done(50, rel);
      checks++;
      if (rel !== 5 || err_count !== 14'd0 || err_flag !== 1'b0) begin
         failures++;
         $display("FAIL b2b_check got cyc=%0d ec=%0d ef=%b want 5 0 0", rel, err_count, err_flag);
      end
   endtask

   task automatic test_reset_mid();
      int rel;
      poke(13'h202, 32'd0);
      push_fill(13'h200, 10, 32'h5000_0000, 1'b1);
      @(negedge clk);
      issue(1'b0, 13'h200, 14'd10, 32'h5000_0000, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_address !== 13'h202) begin
         failures++;
         $display("FAIL mid_third_write got we=%b a=%h want 1 0202", mem_write, mem_address);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_chipselect, mem_write} !== 4'b0 || mem_address !== 13'd0 ||
          mem_writedata !== 32'd0 || mem_byteenable !== 4'hF) begin
         failures++;
         $display("FAIL mid_reset got b=%b d=%b cs=%b we=%b a=%h wd=%h be=%h want 0 be=f",
                  busy, done, mem_chipselect, mem_write, mem_address, mem_writedata,
                  mem_byteenable);
      end
      sb.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      issue(1'b1, 13'h200, 14'd3, 32'h5000_0000, 1'b1);
      wait_done(50, rel);
      checks++;
      if (rel !== 5 || err_count !== 14'd1 || err_flag !== 1'b1 || first_err_addr !== 13'h202) begin
         failures++;
         $display("FAIL after_reset got cyc=%0d ec=%0d ef=%b fa=%h want 5 1 1 0202",
                  rel, err_count, err_flag, first_err_addr);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_check_ok();
      test_check_err();
      test_wrap();
      test_len0();
      test_start_busy();
      test_back_to_back();
      test_clamp();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adder_nios_mem_fill_engine.md
# adder_nios_mem_fill_engine

Avalon-MM master that sits directly upstream of the 8192×32 single-port on-chip RAM in the adder_nios system and drives its slave port. On a start pulse it either fills a contiguous word range with a constant or incrementing pattern, or reads the range back and checks it against the same pattern. It reports an error count and the first failing address. It is used for memory bring-up and scrubbing before the Nios II core is released.

## Interface
- ADDR_W, 13, word-address width of the RAM
- DATA_W, 32, data width
- DEPTH, 8192, number of RAM words; maximum transfer length
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = fill, 1 = check
- base_addr  in  ADDR_W  first word address
- length  in  14  word count, 0..16383; values above DEPTH are clamped to DEPTH
- pattern  in  DATA_W  seed data value
- incr  in  1  1 = the pattern adds 1 per word; 0 = the pattern is constant
- busy  out  1  high while the operation is in progress
- done  out  1  one-cycle completion pulse
- err_flag  out  1  at least one miscompare occurred in the last check
- err_count  out  14  number of miscompares in the last check
- first_err_addr  out  ADDR_W  address of the first miscompare
- mem_address  out  ADDR_W  RAM word address
- mem_byteenable  out  4  RAM byte enables; always 4'hF
- mem_chipselect  out  1  RAM chip select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_readdata  in  DATA_W  RAM read data; valid exactly 1 cycle after the read address

## Operation
- States: IDLE, FILL, CHECK, DRAIN, DONE.
- **IDLE:** when start=1, latch mode, base_addr, length (clamped) and pattern. Clear err_count, err_flag and first_err_addr. Then:
  - length=0: go to DONE.
  - mode=0: go to FILL.
  - mode=1: go to CHECK.
- **Word addressing and data:** word k (k=0..N-1) uses address (base_addr+k) mod DEPTH, so the address wraps from 8191 to 0. Its data is pattern + (incr ? k : 0) mod 2^32.
- **FILL:** one write per cycle with mem_chipselect=1, mem_write=1 and mem_writedata = word k. After word N-1, go to DONE.
- **CHECK:** one read per cycle with mem_chipselect=1 and mem_write=0. The expected value and the address are delayed 1 cycle and compared with mem_readdata.
  - On a mismatch, err_count increments.
  - On the first mismatch only, first_err_addr is loaded with that address and err_flag is set.
  - After issuing word N-1, go to DRAIN. DRAIN performs the final compare and then goes to DONE.
- **DONE:** pulse done for 1 cycle, then return to IDLE.
- start is ignored in every state except IDLE.
- Result outputs hold until the next accepted start. After a fill they read 0.
- err_count cannot overflow, because N ≤ 8192.
- mem_chipselect and mem_write are low in IDLE, DRAIN and DONE.
- All outputs are registered.

## Timing
- Let cycle 0 be the edge at which start is accepted.
- **Fill of N words:** busy is high on cycles 1..N, with writes on cycles 1..N. done is high on cycle N+1 with busy low. Throughput is 1 word per cycle.
- **Check of N words:** reads on cycles 1..N. The compare for word k happens on cycle k+2. busy is high on cycles 1..N+1 (DRAIN is N+1). done is high on cycle N+2, and the results are final on that same cycle.
- **length=0:** done on cycle 1, busy never rises, no RAM access.
- **Back-to-back commands:** a start on the cycle after done is accepted, because the FSM is in IDLE.
- **Reset:** reset_n low at any time, including mid-operation, immediately drives every output to 0 (mem_byteenable to 4'hF) and the state to IDLE. A partially written range is left as-is.

## Structure
- Package adder_nios_mem_pkg holds:
  - constants ADDR_W, DATA_W, DEPTH;
  - mode constants MODE_FILL and MODE_CHECK;
  - the state enum type.
- Sub-module adder_nios_pattern_gen holds the word counter, the wrapping address and the pattern value. It has load and advance inputs and count-last and address/data outputs. It is instantiated once.
- The FSM, the 1-cycle compare pipeline and the result registers live in the top-level module.

## Test plan
- Fill: base=0x10, length=4, pattern=0xA5A5_0000, incr=1 -> writes 0xA5A50000..0xA5A50003 to 0x10..0x13 on cycles 1..4; done on cycle 5.
- Check: the same range read back through the RAM model -> err_count=0, err_flag=0, done on cycle 6.
- Check with word 0x12 corrupted to 0 and word 0x13 to 1 -> err_count=2, first_err_addr=0x12, err_flag=1.
- Wrap: base=0x1FFE, length=4, constant 0xDEADBEEF -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Edge commands:
  - length=0 -> done on cycle 1, no chipselect.
  - length=9000 -> exactly 8192 writes.
  - start while busy -> ignored.
- Reset asserted on the 3rd write of a 10-word fill -> outputs 0 immediately, FSM in IDLE. A subsequent start is accepted normally.
